// File: rtl/mcpu_soc_intsrc_pkg.sv
// mcpu_soc_intsrc_pkg: register map, mode encodings and masked-write helper
package mcpu_soc_intsrc_pkg;
  localparam logic [9:0] ADDR_MODE_LO = 10'h000;
  localparam logic [9:0] ADDR_MODE_HI = 10'h001;
  localparam logic [9:0] ADDR_COAL    = 10'h002;
  localparam logic [9:0] ADDR_STATUS  = 10'h003;
  localparam logic [9:0] ADDR_FORCE   = 10'h004;
  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_LEVEL = 2'b11
  } mode_t;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] val,
                                        input logic [31:0] mask);
    return (old & ~mask) | (val & mask);
  endfunction
endpackage

// File: rtl/mcpu_soc_intsrc_edge.sv
// mcpu_soc_intsrc_edge: per-event edge/level detector
module mcpu_soc_intsrc_edge
  import mcpu_soc_intsrc_pkg::*;
(
  input  logic  event_in,
  input  logic  event_prev,
  input  mode_t mode,
  output logic  detect
);
  always_comb
    detect = mode == MODE_RISE ? event_in & ~event_prev :
             mode == MODE_FALL ? ~event_in & event_prev :
             mode == MODE_LEVEL ? event_in : 1'b0;
endmodule

// File: rtl/mcpu_soc_intsrc.sv
// mcpu_soc_intsrc: event detection, interrupt coalescing and MMIO registers
module mcpu_soc_intsrc
  import mcpu_soc_intsrc_pkg::*;
#(
  parameter int NUM_EVENTS = 32
) (
  input  logic                  clkrst_core_clk,
  input  logic                  clkrst_core_rst_n,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic [9:0]            addr,
  input  logic [31:0]           data_in,
  input  logic [31:0]           write_mask,
  output logic [31:0]           data_out,
  output logic [31:0]           interrupt_trigger
);
  logic [NUM_EVENTS-1:0] event_prev, accum, detect;
  logic [31:0] mode_lo, mode_hi, force_raw, force_bits;
  logic [63:0] mode_all;
  logic [23:0] coal;
  logic [15:0] timer;
  logic [7:0]  count, count_next, thresh;
  logic        fire;
  assign mode_all = {mode_hi, mode_lo};
  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_edge
    mcpu_soc_intsrc_edge u_edge (
      .event_in  (event_in[i]),
      .event_prev(event_prev[i]),
      .mode      (mode_t'(mode_all[2*i +: 2])),
      .detect    (detect[i])
    );
  end
  // count_next includes this cycle's detection so a fire never drops it
  always_comb begin
    thresh     = coal[7:0] == 8'd0 ? 8'd1 : coal[7:0];
    count_next = count + {7'd0, |detect && count != 8'hFF};
    fire       = count_next >= thresh ||
                 (coal[23:8] != 16'd0 && |accum && 17'(timer) + 17'd1 >= 17'(coal[23:8]));
    force_raw  = addr == ADDR_FORCE ? data_in & write_mask : 32'd0;
    force_bits = 32'(force_raw[NUM_EVENTS-1:0]);
    data_out   = addr == ADDR_MODE_LO ? mode_lo :
                 addr == ADDR_MODE_HI ? mode_hi :
                 addr == ADDR_COAL    ? {8'd0, coal} :
                 addr == ADDR_STATUS  ? {8'd0, timer, count} : 32'd0;
  end
  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      mode_lo           <= '0;
      mode_hi           <= '0;
      coal              <= 24'd1;
      event_prev        <= '0;
      accum             <= '0;
      count             <= '0;
      timer             <= '0;
      interrupt_trigger <= '0;
    end else begin
      event_prev <= event_in;
      if (addr == ADDR_MODE_LO) mode_lo <= merge(mode_lo, data_in, write_mask);
      if (addr == ADDR_MODE_HI) mode_hi <= merge(mode_hi, data_in, write_mask);
      if (addr == ADDR_COAL) coal <= merge({8'd0, coal}, data_in, write_mask) & 24'hFFFFFF;
      interrupt_trigger <= (fire ? 32'(accum | detect) : 32'd0) | force_bits;
      accum <= fire ? '0 : accum | detect;
      count <= fire ? 8'd0 : count_next;
      timer <= fire || ~|accum ? 16'd0 : timer + 16'd1;
    end
  end
endmodule
